serial_frame_rx: RTL and testbench

//  Receive end of the byte-serial link: recovers framed serial data (start bit, DATA_W bits
//  LSB-first, optional parity, stop bit) from line si and buffers complete words in a small

---
 rtl/serial_frame_rx_pkg.sv | 17 +
 rtl/serial_frame_rx_fifo.sv | 52 +++++
 rtl/serial_frame_rx.sv | 141 ++++++++++++++
 tb/tb_serial_frame_rx.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/serial_frame_rx_pkg.sv
// Shared types and defaults for the serial frame receiver.
package serial_frame_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } rx_state_t;

  localparam logic IDLE_LVL         = 1'b1;
  localparam int   DEF_DATA_W       = 8;
  localparam int   DEF_CLKS_PER_BIT = 16;

endpackage

// File: rtl/serial_frame_rx_fifo.sv
// Synchronous word FIFO with registered read port; DEPTH must be a power of 2 (>=2).
module rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_din,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_drop
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [AW:0]       r_cnt;
  logic              w_pop, w_wr;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_wr    = i_push && (!o_full || w_pop);
  assign o_drop  = i_push && !w_wr;

  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wptr] <= i_din;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_cnt     <= '0;
      o_rd_data <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr    <= r_rptr + 1'b1;
        o_rd_data <= r_mem[r_rptr];
      end
      case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: synchroniser, bit timing, framing FSM and word FIFO.
// Define PARITY_EN to expect an even-parity bit between the data and stop bits.
module serial_frame_rx
  import serial_frame_rx_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              si,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic              frame_err,
  output logic              overrun,
  output logic              parity_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W + 1);

  rx_state_t         r_state;
  logic              r_si_meta, r_si_s;
  logic [CW-1:0]     r_cnt;
  logic [BW-1:0]     r_bit;
  logic [DATA_W-1:0] r_shift;
  logic              r_frame_err, r_overrun;
  logic              w_half, w_full_bit, w_stop_smp, w_push, w_drop, w_par_bad;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_si_meta <= IDLE_LVL;
      r_si_s    <= IDLE_LVL;
    end else begin
      r_si_meta <= si;
      r_si_s    <= r_si_meta;
    end
  end

  assign w_half     = (r_cnt == CW'(CLKS_PER_BIT/2 - 1));
  assign w_full_bit = (r_cnt == CW'(CLKS_PER_BIT - 1));
  assign w_stop_smp = (r_state == S_STOP) && w_full_bit;
  assign w_push     = w_stop_smp && r_si_s && !w_par_bad;

`ifdef PARITY_EN
  logic r_par_bad, r_parity_err;
  assign w_par_bad  = r_par_bad;
  assign parity_err = r_parity_err;
`else
  assign w_par_bad  = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef PARITY_EN
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= w_drop;
`ifdef PARITY_EN
      r_parity_err <= w_stop_smp && r_par_bad;
`endif
      case (r_state)
        S_IDLE:
          if (!r_si_s) begin
            r_state <= S_START;
            r_cnt   <= '0;
          end
        // Re-check the line at mid start bit so short glitches are ignored.
        S_START:
          if (w_half) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= r_si_s ? S_IDLE : S_DATA;
`ifdef PARITY_EN
            r_par_bad <= 1'b0;
`endif
          end else r_cnt <= r_cnt + 1'b1;
        S_DATA:
          if (w_full_bit) begin
            r_cnt   <= '0;
            r_shift <= {r_si_s, r_shift[DATA_W-1:1]};
            r_bit   <= r_bit + 1'b1;
            if (r_bit == BW'(DATA_W - 1))
`ifdef PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
          end else r_cnt <= r_cnt + 1'b1;
`ifdef PARITY_EN
        S_PARITY:
          if (w_full_bit) begin
            r_cnt     <= '0;
            r_par_bad <= r_si_s ^ (^r_shift);
            r_state   <= S_STOP;
          end else r_cnt <= r_cnt + 1'b1;
`endif
        S_STOP:
          if (w_full_bit) begin
            r_cnt <= '0;
            if (r_si_s) r_state <= S_IDLE;
            else begin
              r_frame_err <= 1'b1;
              r_state     <= S_BREAK;
            end
          end else r_cnt <= r_cnt + 1'b1;
        // Held-low line must go high before another start can be detected.
        S_BREAK:
          if (r_si_s) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

  rx_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_din     (r_shift),
    .i_pop     (rd_en),
    .o_rd_data (rd_data),
    .o_empty   (empty),
    .o_full    (full),
    .o_drop    (w_drop)
  );
endmodule

// File: tb/tb_serial_frame_rx.sv
// Randomised self-checking bench for serial_frame_rx against a queue-based model.
module tb_serial_frame_rx;
  localparam int CPB = 16;
  localparam int DEPTH = 4;

  logic       clk, rst, si, rd_en;
  logic [7:0] rd_data;
  logic       empty, full, frame_err, overrun, parity_err;

  serial_frame_rx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .si(si), .rd_en(rd_en), .rd_data(rd_data), .empty(empty),
    .full(full), .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int n_fe = 0, n_ov = 0, n_pe = 0;
  logic [7:0] q[$];
  logic [7:0] last_rd;

  always @(negedge clk) begin
    if (frame_err)  n_fe++;
    if (overrun)    n_ov++;
    if (parity_err) n_pe++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one frame on si; optionally raise rd_en for the cycle the receiver samples the stop bit.
  task automatic send(input logic [7:0] d, input logic stop, input logic flip,
                      input logic pop_at_stop, input int hold_low);
    logic bits[11];
    int nb, smp;
    nb = 0;
    bits[nb++] = 1'b0;
    for (int i = 0; i < 8; i++) bits[nb++] = d[i];
`ifdef PARITY_EN
    bits[nb++] = (^d) ^ flip;
`endif
    bits[nb++] = stop;
    // Two synchroniser flops, one idle-detect cycle, half a bit, then full bits to the stop centre.
    smp = 3 + CPB/2 + CPB*(nb-1) - 1;
    for (int c = 0; c < nb*CPB; c++) begin
      si = bits[c/CPB];
      if (pop_at_stop) rd_en = (c == smp);
      tick(1);
    end
    rd_en = 1'b0;
    if (hold_low > 0) begin
      si = 1'b0;
      tick(hold_low);
    end
    si = 1'b1;
    tick(2*CPB);
  endtask

  task automatic frame(input logic [7:0] d, input logic stop, input logic flip, input logic pop);
    int fe0, ov0, pe0;
    logic exp_ov, good, popped;
    fe0 = n_fe; ov0 = n_ov; pe0 = n_pe;
    exp_ov = 1'b0;
    popped = 1'b0;
`ifndef PARITY_EN
    flip = 1'b0;
`endif
    good = stop && !flip;
    send(d, stop, flip, pop, 0);
    if (pop && q.size() > 0) begin
      last_rd = q.pop_front();
      popped = 1'b1;
    end
    if (good) begin
      if (q.size() < DEPTH) q.push_back(d);
      else exp_ov = 1'b1;
    end
    chk("frame_err", n_fe - fe0, {31'd0, !stop});
    chk("overrun", n_ov - ov0, {31'd0, exp_ov});
    chk("parity_err", n_pe - pe0, {31'd0, flip});
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEPTH);
    if (popped) chk("rd_at_stop", rd_data, last_rd);
  endtask

  task automatic rd();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    if (q.size() > 0) last_rd = q.pop_front();
    chk("rd_data", rd_data, last_rd);
    chk("empty_after_rd", empty, q.size() == 0);
  endtask

  initial begin
    int fe0, ov0, pe0;
    rst = 1'b0; si = 1'b1; rd_en = 1'b0; last_rd = 8'h00;
    tick(3);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_pulses", {frame_err, overrun, parity_err}, 0);
    rst = 1'b1;
    tick(4);

    frame(8'h12, 1'b1, 1'b0, 1'b0);
    rd();

    // Short low glitch on an idle line.
    fe0 = n_fe; ov0 = n_ov; pe0 = n_pe;
    si = 1'b0; tick(3); si = 1'b1; tick(3*CPB);
    chk("glitch_empty", empty, 1);
    chk("glitch_flags", (n_fe - fe0) + (n_ov - ov0) + (n_pe - pe0), 0);

    // Bad stop bit, then a long break before the line recovers.
    fe0 = n_fe;
    send(8'hA5, 1'b0, 1'b0, 1'b0, 100);
    chk("break_fe", n_fe - fe0, 1);
    chk("break_empty", empty, 1);
    frame(8'h3C, 1'b1, 1'b0, 1'b0);
    rd();

    for (int i = 1; i <= 5; i++) frame(i[7:0], 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) rd();

    // Full FIFO with a pop landing on the stop-sample cycle.
    for (int i = 0; i < 4; i++) frame(8'($urandom), 1'b1, 1'b0, 1'b0);
    frame(8'h77, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) rd();
    chk("last_is_77", last_rd, 8'h77);
    rd();

    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 2) != 0)
        frame(8'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 3) == 0);
      else rd();
    end
    while (q.size() > 0) rd();

`ifdef PARITY_EN
    frame(8'h5A, 1'b1, 1'b1, 1'b0);
`endif

    // Reset during the data bits drops both the partial frame and stored words.
    frame(8'h11, 1'b1, 1'b0, 1'b0);
    si = 1'b0; tick(3*CPB);
    rst = 1'b0; tick(2);
    q.delete();
    last_rd = 8'h00;
    chk("midrst_empty", empty, 1);
    chk("midrst_rd_data", rd_data, 0);
    si = 1'b1; tick(2);
    rst = 1'b1; tick(2*CPB);
    frame(8'h5A, 1'b1, 1'b0, 1'b0);
    rd();
    chk("midrst_last", last_rd, 8'h5A);
    rd();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
